// File: rtl/pe_input_stage.sv
// rtl/pe_input_stage.sv - buffers the first half of each frame and emits (x[k], x[k+N/2]) operand pairs with the aligned twiddle
// Optional PE_IN_FRAME_CNT_EN adds a saturating completed-frame counter on frames_done.
module pe_input_stage #(
    parameter int WORDSIZE = 16,
    parameter int N        = 16,
    parameter int LOGN     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [WORDSIZE-1:0] in_re,
    input  logic [WORDSIZE-1:0] in_im,
    input  logic                tw_we,
    input  logic [LOGN-2:0]     tw_waddr,
    input  logic [WORDSIZE-1:0] tw_wdata,
    output logic                out_valid,
    output logic [WORDSIZE-1:0] out0,
    output logic [WORDSIZE-1:0] out1,
    output logic [WORDSIZE-1:0] out2,
    output logic [WORDSIZE-1:0] out3,
    output logic [WORDSIZE-1:0] twiddle,
    output logic [LOGN-2:0]     out_k,
`ifdef PE_IN_FRAME_CNT_EN
    output logic [15:0]         frames_done,
`endif
    output logic                frame_err
);

    localparam int HALF = N / 2;
    localparam logic [WORDSIZE-1:0] TW_RESET = WORDSIZE'(16'h0400);

    typedef enum logic {FILL, PAIR} state_t;

    state_t          state_q, state_d;
    logic [LOGN-1:0] cnt_q, cnt_d;

    logic            restart;
    logic            buf_we;
    logic [LOGN-2:0] buf_waddr;
    logic            pair_fire;
    logic [LOGN-2:0] pair_k;

    logic [WORDSIZE-1:0] smp_re_q [HALF];
    logic [WORDSIZE-1:0] smp_im_q [HALF];
    logic [WORDSIZE-1:0] tw_q     [HALF];

    logic                out_valid_q;
    logic [WORDSIZE-1:0] out0_q, out1_q, out2_q, out3_q, twiddle_q;
    logic [LOGN-2:0]     out_k_q;
    logic                frame_err_q;

    // A start-of-frame mid-frame abandons the partial frame and restarts at index 0.
    assign restart = in_valid && in_sof && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_valid) begin
            if (restart) begin
                cnt_d   = LOGN'(1);
                state_d = FILL;
            end else begin
                cnt_d = cnt_q + LOGN'(1);
                if (cnt_q == LOGN'(HALF - 1))
                    state_d = PAIR;
                else if (cnt_q == LOGN'(N - 1))
                    state_d = FILL;
            end
        end
    end

    // Second-half index k = cnt - N/2 is just the low bits of cnt while in PAIR.
    always_comb begin
        buf_we    = in_valid && (restart || state_q == FILL);
        buf_waddr = restart ? '0 : cnt_q[LOGN-2:0];
        pair_fire = in_valid && !restart && (state_q == PAIR);
        pair_k    = cnt_q[LOGN-2:0];
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            smp_re_q[buf_waddr] <= in_re;
            smp_im_q[buf_waddr] <= in_im;
        end
    end

    // Read of tw_q below sees the pre-write value on a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HALF; i++)
                tw_q[i] <= TW_RESET;
        end else if (tw_we) begin
            tw_q[tw_waddr] <= tw_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
            twiddle_q   <= '0;
            out_k_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            out_valid_q <= pair_fire;
            frame_err_q <= frame_err_q | restart;
            if (pair_fire) begin
                out0_q    <= smp_re_q[pair_k];
                out1_q    <= in_re;
                out2_q    <= smp_im_q[pair_k];
                out3_q    <= in_im;
                twiddle_q <= tw_q[pair_k];
                out_k_q   <= pair_k;
            end
        end
    end

`ifdef PE_IN_FRAME_CNT_EN
    logic [15:0] frames_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frames_q <= '0;
        else if (out_valid_q && out_k_q == (LOGN-1)'(HALF - 1) && frames_q != 16'hFFFF)
            frames_q <= frames_q + 16'd1;
    end

    assign frames_done = frames_q;
`endif

    assign out_valid = out_valid_q;
    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out2      = out2_q;
    assign out3      = out3_q;
    assign twiddle   = twiddle_q;
    assign out_k     = out_k_q;
    assign frame_err = frame_err_q;

endmodule
